clause1: RTL and testbench

CLAUSE1 -- requirements
Module: clause1

---
 rtl/clause1.sv | 74 +++++++
 tb/tb_clause1.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/clause1.sv
// Single SAT clause: stores one literal per variable slot and drives either a
// unit implication or a conflict onto the variable bus, purely combinationally.
module clause1 #(
  parameter int unsigned NUM_VARS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_i,
  input  logic [NUM_VARS*3-1:0]   var_value_i,
  output logic [NUM_VARS*3-1:0]   var_value_o,
  input  logic [4:0]              clause_len_i,
  output logic [4:0]              clause_len_o,
  input  logic                    apply_backtrack_i
);

  localparam int unsigned CW = $clog2(NUM_VARS + 1);

  logic [NUM_VARS-1:0][1:0] lit_q;
  logic                     clausesat_0;
  logic [CW-1:0]            freelitcnt_0;
  logic                     any_member;
  logic                     imp_drv_0;
  logic                     cclause_drv_0;

  // Literal and length storage; reset clears every slot to absent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lit_q        <= '0;
      clause_len_o <= '0;
    end else if (wr_i) begin
      for (int i = 0; i < int'(NUM_VARS); i++) begin
        lit_q[i] <= var_value_i[3*i+1 +: 2];
      end
      clause_len_o <= clause_len_i;
    end
  end

  // Clause evaluation against the current variable assignment.
  always_comb begin
    clausesat_0  = 1'b0;
    freelitcnt_0 = '0;
    any_member   = 1'b0;
    for (int i = 0; i < int'(NUM_VARS); i++) begin
      if (lit_q[i] != 2'b00) begin
        any_member = 1'b1;
        if (var_value_i[3*i+1 +: 2] == lit_q[i]) begin
          clausesat_0 = 1'b1;
        end
        if (var_value_i[3*i+1 +: 2] == 2'b00) begin
          freelitcnt_0 = freelitcnt_0 + CW'(1);
        end
      end
    end
  end

  assign imp_drv_0     = !clausesat_0 && (freelitcnt_0 == CW'(1)) && !apply_backtrack_i;
  assign cclause_drv_0 = !clausesat_0 && (freelitcnt_0 == CW'(0)) && any_member
                         && !apply_backtrack_i;

  // Drive the lone free literal as implied, or flag every member as conflicting.
  always_comb begin
    var_value_o = '0;
    for (int i = 0; i < int'(NUM_VARS); i++) begin
      if (lit_q[i] != 2'b00) begin
        if (imp_drv_0 && (var_value_i[3*i+1 +: 2] == 2'b00)) begin
          var_value_o[3*i +: 3] = {lit_q[i], 1'b1};
        end else if (cclause_drv_0) begin
          var_value_o[3*i +: 3] = {2'b11, var_value_i[3*i]};
        end
      end
    end
  end

endmodule

// File: tb/tb_clause1.sv
// Bench for clause1: directed scenarios followed by randomized traffic checked
// against a slot-list model of the clause.
module tb_clause1;

  localparam int unsigned NV = 8;
  localparam int unsigned W  = NV * 3;

  logic         clk;
  logic         rst;
  logic         wr_i;
  logic [W-1:0] var_value_i;
  logic [W-1:0] var_value_o;
  logic [4:0]   clause_len_i;
  logic [4:0]   clause_len_o;
  logic         apply_backtrack_i;

  int total = 0;
  int bad   = 0;

  logic [1:0] m_lit [NV];
  logic [4:0] m_len;

  clause1 #(.NUM_VARS(NV)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_i             (wr_i),
    .var_value_i      (var_value_i),
    .var_value_o      (var_value_o),
    .clause_len_i     (clause_len_i),
    .clause_len_o     (clause_len_o),
    .apply_backtrack_i(apply_backtrack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Classify each member slot as true/free/false, then pick the clause action.
  task automatic model(input logic [W-1:0] v, input logic bt,
                       output logic sat, output int nfree, output logic [W-1:0] o);
    int nmem;
    int fidx;
    logic [1:0] val;
    sat = 1'b0; nfree = 0; nmem = 0; fidx = -1; o = '0;
    for (int i = 0; i < int'(NV); i++) begin
      val = v[3*i+1 +: 2];
      if (m_lit[i] != 2'b00) begin
        nmem++;
        if (val == m_lit[i]) sat = 1'b1;
        else if (val == 2'b00) begin nfree++; fidx = i; end
      end
    end
    if (!bt && !sat && nfree == 1) begin
      o[3*fidx +: 3] = {m_lit[fidx], 1'b1};
    end else if (!bt && !sat && nfree == 0 && nmem > 0) begin
      for (int i = 0; i < int'(NV); i++)
        if (m_lit[i] != 2'b00) o[3*i +: 3] = {2'b11, v[3*i]};
    end
  endtask

  // Apply inputs between edges and compare every observable against the model.
  task automatic apply_and_check(input string tag, input logic [W-1:0] v, input logic bt);
    logic sat;
    int nfree;
    logic [W-1:0] o;
    var_value_i = v;
    apply_backtrack_i = bt;
    #1;
    model(v, bt, sat, nfree, o);
    check({tag, ".out"}, 32'(var_value_o), 32'(o));
    check({tag, ".sat"}, 32'(dut.clausesat_0), 32'(sat));
    check({tag, ".free"}, 32'(dut.freelitcnt_0), 32'(nfree));
    check({tag, ".len"}, 32'(clause_len_o), 32'(m_len));
  endtask

  task automatic do_write(input logic [W-1:0] v, input logic [4:0] len);
    var_value_i  = v;
    clause_len_i = len;
    wr_i         = 1'b1;
    @(posedge clk);
    #1;
    wr_i = 1'b0;
    if (rst) begin
      for (int i = 0; i < int'(NV); i++) m_lit[i] = v[3*i+1 +: 2];
      m_len = len;
    end
  endtask

  function automatic logic [W-1:0] rand_clause();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NV); i++) v[3*i+1 +: 2] = 2'($urandom_range(0, 2));
    return v;
  endfunction

  function automatic logic [W-1:0] rand_assign();
    logic [W-1:0] v;
    int r;
    v = '0;
    for (int i = 0; i < int'(NV); i++) begin
      r = $urandom_range(0, 9);
      if (m_lit[i] == 2'b00)  v[3*i+1 +: 2] = 2'($urandom_range(0, 3));
      else if (r < 2)         v[3*i+1 +: 2] = 2'b00;
      else if (r < 3)         v[3*i+1 +: 2] = m_lit[i];
      else if (r < 8)         v[3*i+1 +: 2] = m_lit[i] ^ 2'b11;
      else                    v[3*i+1 +: 2] = 2'b11;
      v[3*i] = 1'($urandom_range(0, 1));
    end
    return v;
  endfunction

  initial begin
    logic [W-1:0] v;
    for (int i = 0; i < int'(NV); i++) m_lit[i] = 2'b00;
    m_len = '0;
    rst = 1'b0;
    wr_i = 1'b1;
    var_value_i = W'($urandom);
    clause_len_i = 5'd17;
    apply_backtrack_i = 1'b0;

    // Reset holds everything at zero and ignores writes.
    #3;
    check("rst.len", 32'(clause_len_o), 32'd0);
    check("rst.out", 32'(var_value_o), 32'd0);
    check("rst.free", 32'(dut.freelitcnt_0), 32'd0);
    check("rst.cc", 32'(dut.cclause_drv_0), 32'd0);
    @(posedge clk);
    #1;
    check("rst.wr_ignored", 32'(clause_len_o), 32'd0);
    check("rst.sat", 32'(dut.clausesat_0), 32'd0);
    rst = 1'b1;
    wr_i = 1'b0;
    @(posedge clk);
    #1;

    // Write scenario: slot1=01, slot3=10, slot5=10.
    v = '0;
    v[5:3] = 3'b010; v[11:9] = 3'b100; v[17:15] = 3'b100;
    do_write(v, 5'd3);
    check("wr.sat", 32'(dut.clausesat_0), 32'd1);
    check("wr.len", 32'(clause_len_o), 32'd3);
    check("wr.out", 32'(var_value_o), 32'd0);

    // All free.
    apply_and_check("free", '0, 1'b0);
    check("free.cnt3", 32'(dut.freelitcnt_0), 32'd3);
    check("free.out0", 32'(var_value_o), 32'd0);

    // Implication onto slot3.
    v = '0;
    v[5:3] = 3'b100; v[17:15] = 3'b010;
    apply_and_check("imp", v, 1'b0);
    check("imp.drv", 32'(dut.imp_drv_0), 32'd1);
    check("imp.out_const", 32'(var_value_o), 32'h000A00);

    // Conflict: slot3 forced to 11 with implied flag.
    v[11:9] = 3'b111;
    apply_and_check("cc", v, 1'b0);
    check("cc.drv", 32'(dut.cclause_drv_0), 32'd1);
    check("cc.imp_excl", 32'(dut.imp_drv_0), 32'd0);
    check("cc.out_const", 32'(var_value_o), 32'h030E30);

    // Backtrack suppresses the conflict drive.
    apply_and_check("bt", v, 1'b1);
    check("bt.drv", 32'(dut.cclause_drv_0), 32'd0);
    check("bt.out_const", 32'(var_value_o), 32'd0);
    apply_backtrack_i = 1'b0;

    // Randomized traffic: occasional rewrites, mixed assignments and backtracks.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        do_write(rand_clause(), 5'($urandom));
      end
      apply_and_check("rnd", rand_assign(), 1'($urandom_range(0, 4) == 0));
      @(posedge clk);
      #1;
    end
    apply_backtrack_i = 1'b0;

    // Asynchronous reset mid-cycle.
    do_write(v, 5'd9);
    #2;
    rst = 1'b0;
    #1;
    check("mrst.len", 32'(clause_len_o), 32'd0);
    var_value_i = W'($urandom);
    #1;
    check("mrst.free", 32'(dut.freelitcnt_0), 32'd0);
    check("mrst.out", 32'(var_value_o), 32'd0);
    for (int i = 0; i < int'(NV); i++) m_lit[i] = 2'b00;
    m_len = '0;
    do_write(rand_clause(), 5'd21);
    check("mrst.wr_ignored", 32'(clause_len_o), 32'd0);
    rst = 1'b1;
    #1;
    do_write(rand_clause(), 5'd21);
    check("mrst.resume", 32'(clause_len_o), 32'd21);
    for (int n = 0; n < 20; n++) begin
      apply_and_check("post", rand_assign(), 1'b0);
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
